led_frame_sched: RTL and testbench

- Frame scheduler between the I2C slave byte interface and the WS2812-style LED bit serializer.
- Collects I2C payload bytes into a shadow frame buffer and commits it on STOP.
- Streams the committed frame, one byte per valid/ready handshake, to the serializer, then enforces the reset/latch gap.
- Decouples I2C writes from LED refresh, so a new frame can be written while the previous one is streaming.

---
 rtl/led_frame_sched.sv | 110 +++++++++++
 tb/tb_led_frame_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sched.sv
// Frame scheduler: collects I2C payload bytes into a shadow buffer and commits them on STOP.
// It then streams the committed frame to the LED serializer and holds the latch gap.
module led_frame_sched #(
  parameter int LED_CNT      = 3,
  parameter int LATCH_CYCLES = 1250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  input  logic       frame_start_i,
  input  logic       frame_end_i,
  input  logic       byte_ready_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int FLEN = 3 * LED_CNT;
  localparam int PW   = $clog2(FLEN + 1);
  localparam int CW   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [PW-1:0] FLEN_P = PW'(FLEN);
  localparam logic [PW-1:0] LAST_P = PW'(FLEN - 1);
  localparam logic [CW-1:0] CNT_LD = CW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, LATCH} state_t;

  state_t                 state;
  logic [FLEN-1:0][7:0]   shadow;
  logic [FLEN-1:0][7:0]   active;
  logic [PW-1:0]          wp;
  logic [PW-1:0]          rp;
  logic [CW-1:0]          cnt;
  logic                   pending;
  logic                   ovf;
  logic [7:0]             data_q;

  // Write side runs regardless of FSM state; frame_start rewinds but still takes a same-cycle byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      wp     <= '0;
      ovf    <= 1'b0;
    end else if (frame_start_i) begin
      ovf <= 1'b0;
      if (wr_valid_i) begin
        shadow[0] <= wr_data_i;
        wp        <= PW'(1);
      end else begin
        wp <= '0;
      end
    end else if (wr_valid_i) begin
      if (wp != FLEN_P) begin
        shadow[wp] <= wr_data_i;
        wp         <= wp + 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  // A STOP seen in IDLE goes straight to LOAD so the first byte is valid two cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      active  <= '0;
      rp      <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      data_q  <= '0;
    end else begin
      if (frame_end_i)
        pending <= 1'b1;
      else if (state == LOAD)
        pending <= 1'b0;

      case (state)
        IDLE: if (pending || frame_end_i) state <= LOAD;
        LOAD: begin
          active <= shadow;
          data_q <= shadow[0];
          rp     <= '0;
          state  <= STREAM;
        end
        STREAM: if (byte_ready_i) begin
          if (rp == LAST_P) begin
            state <= LATCH;
            cnt   <= CNT_LD;
          end else begin
            rp     <= rp + 1'b1;
            data_q <= active[rp + 1'b1];
          end
        end
        LATCH: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_valid_o = (state == STREAM);
  assign byte_data_o  = data_q;
  assign busy_o       = pending | (state != IDLE);
  assign overflow_o   = ovf;

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched: streaming, stalls, double buffering, overflow, partial frames and reset.
module tb_led_frame_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       frame_start_i = 1'b0;
  logic       frame_end_i = 1'b0;
  logic       byte_ready_i = 1'b0;
  logic       byte_valid_o;
  logic [7:0] byte_data_o;
  logic       busy_o;
  logic       overflow_o;

  int tests = 0;
  int fails = 0;

  typedef logic [7:0] frame_t [9];
  frame_t f1 = '{8'hAB, 8'h36, 8'h84, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  frame_t f2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  frame_t f4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
  frame_t f5 = '{8'h7F, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  frame_t fz = '{default: 8'h00};

  always #5 clk = ~clk;

  led_frame_sched dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .frame_start_i(frame_start_i),
    .frame_end_i  (frame_end_i),
    .byte_ready_i (byte_ready_i),
    .byte_valid_o (byte_valid_o),
    .byte_data_o  (byte_data_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    step();
    wr_valid_i = 1'b0;
  endtask

  // STOP pulse, then LOAD cycle, then first valid byte.
  task automatic commit(input string tag);
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
    chk({tag, "_load_valid"}, 32'(byte_valid_o), 32'd0);
    chk({tag, "_load_busy"}, 32'(busy_o), 32'd1);
    step();
    chk({tag, "_valid_rise"}, 32'(byte_valid_o), 32'd1);
  endtask

  // Consume one frame; stall uses ready 1-high/2-low; feed writes 11..99 plus STOP meanwhile.
  task automatic stream(input string tag, input frame_t e, input bit stall, input bit feed);
    int idx = 0;
    int cyc = 0;
    while (idx < 9 && cyc < 200) begin
      byte_ready_i = stall ? (cyc % 3 == 0) : 1'b1;
      if (feed) begin
        frame_start_i = (cyc == 0);
        wr_valid_i    = (cyc >= 1 && cyc <= 9);
        wr_data_i     = 8'(cyc * 17);
        frame_end_i   = (cyc == 10);
      end
      chk({tag, "_valid"}, 32'(byte_valid_o), 32'd1);
      chk({tag, "_data"}, 32'(byte_data_o), 32'(e[idx]));
      if (byte_ready_i) idx++;
      step();
      cyc++;
    end
    frame_start_i = 1'b0;
    wr_valid_i    = 1'b0;
    frame_end_i   = 1'b0;
    byte_ready_i  = 1'b1;
    chk({tag, "_count"}, 32'(idx), 32'd9);
    chk({tag, "_done"}, 32'(byte_valid_o), 32'd0);
  endtask

  task automatic latch(input string tag, input bit exp_busy);
    int bad = 0;
    for (int k = 0; k < 1250; k++) begin
      if (byte_valid_o !== 1'b0 || busy_o !== 1'b1) bad++;
      step();
    end
    chk({tag, "_latch_gap"}, 32'(bad), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy_o), 32'(exp_busy));
    chk({tag, "_valid_after"}, 32'(byte_valid_o), 32'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_valid", 32'(byte_valid_o), 32'd0);
    chk("rst_data", 32'(byte_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    reset = 1'b0;
    step();
    byte_ready_i = 1'b1;

    // Full frame, free-running ready.
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    for (int i = 0; i < 9; i++) wr(f1[i]);
    chk("s1_ovf", 32'(overflow_o), 32'd0);
    commit("s1");
    stream("s1", f1, 1'b0, 1'b0);
    latch("s1", 1'b0);

    // Same shadow recommitted, streamed under back-pressure.
    commit("s2");
    stream("s2", f1, 1'b1, 1'b0);
    latch("s2", 1'b0);

    // Partial frame; last byte shares the cycle with STOP.
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    wr(8'h7F);
    wr(8'h00);
    frame_end_i = 1'b1;
    wr(8'hFF);
    frame_end_i = 1'b0;
    chk("s5_load_valid", 32'(byte_valid_o), 32'd0);
    step();
    chk("s5_valid_rise", 32'(byte_valid_o), 32'd1);
    stream("s5", f5, 1'b0, 1'b0);
    latch("s5", 1'b0);

    // Second frame written and committed while the first streams.
    commit("s3a");
    stream("s3a", f5, 1'b1, 1'b1);
    latch("s3a", 1'b1);
    step();
    chk("s3_idle_valid", 32'(byte_valid_o), 32'd0);
    step();
    chk("s3_gap", 32'(byte_valid_o), 32'd1);
    stream("s3b", f2, 1'b0, 1'b0);
    latch("s3b", 1'b0);

    // Overflow; first byte shares the cycle with frame_start.
    frame_start_i = 1'b1;
    wr_valid_i    = 1'b1;
    wr_data_i     = f4[0];
    step();
    frame_start_i = 1'b0;
    wr_valid_i    = 1'b0;
    for (int i = 1; i < 9; i++) wr(f4[i]);
    chk("s4_ovf_full", 32'(overflow_o), 32'd0);
    wr(8'hEE);
    chk("s4_ovf_set", 32'(overflow_o), 32'd1);
    commit("s4");
    stream("s4", f4, 1'b0, 1'b0);
    latch("s4", 1'b0);
    chk("s4_ovf_sticky", 32'(overflow_o), 32'd1);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    chk("s4_ovf_clear", 32'(overflow_o), 32'd0);

    // Reset while the 5th byte is on the bus.
    commit("s6");
    for (int i = 0; i < 4; i++) begin
      chk("s6_pre_data", 32'(byte_data_o), 32'(f4[i]));
      step();
    end
    chk("s6_byte5", 32'(byte_data_o), 32'(f4[4]));
    reset = 1'b1;
    #1;
    chk("s6_rst_valid", 32'(byte_valid_o), 32'd0);
    chk("s6_rst_busy", 32'(busy_o), 32'd0);
    chk("s6_rst_data", 32'(byte_data_o), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("s6_idle_busy", 32'(busy_o), 32'd0);
    commit("s6z");
    stream("s6z", fz, 1'b0, 1'b0);
    latch("s6z", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
